fft_stage_ctrl: RTL and testbench

Sequencer for the in-place radix-2 DIF FFT (N = 2**LOG2N points, default 16).
- Walks all LOG2N stages × N/2 butterflies.
- Issues per cycle: data-buffer read addresses (a, b), the stage twiddle-ROM address (3-bit for N = 16) and the matching write-back addresses, delayed by the butterfly pipeline latency.
- Inserts drain gaps between stages to avoid read-after-write hazards.
- Signals frame completion.

---
 rtl/fft_stage_ctrl.sv | 136 +++++++++++++
 tb/tb_fft_stage_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/fft_stage_ctrl.sv
// fft_stage_ctrl: stage/butterfly address sequencer for an in-place radix-2 DIF FFT
module fft_stage_ctrl #(
  parameter int LOG2N    = 4,
  parameter int BFLY_LAT = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_start,
  input  logic                     i_abort,
  output logic                     o_busy,
  output logic                     o_rd_en,
  output logic [LOG2N-1:0]         o_rd_addr_a,
  output logic [LOG2N-1:0]         o_rd_addr_b,
  output logic [LOG2N-2:0]         o_tw_addr,
  output logic [$clog2(LOG2N)-1:0] o_stage,
  output logic                     o_wr_en,
  output logic [LOG2N-1:0]         o_wr_addr_a,
  output logic [LOG2N-1:0]         o_wr_addr_b,
  output logic                     o_done
);
  localparam int SW = $clog2(LOG2N);
  localparam int KW = LOG2N - 1;
  localparam int DW = (BFLY_LAT > 1) ? $clog2(BFLY_LAT) : 1;
  localparam logic [LOG2N-1:0] HALF = LOG2N'(1) << KW;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t           r_state, w_state_nx;
  logic [KW-1:0]    r_k, w_k_nx;
  logic [SW-1:0]    r_stg, w_stg_nx;
  logic [DW-1:0]    r_d, w_d_nx;
  logic [LOG2N-1:0] w_span, w_mask, w_kx, w_idx, w_a, w_tw;
  logic             w_iss;
  logic             r_pv [BFLY_LAT];
  logic [LOG2N-1:0] r_pa [BFLY_LAT];
  logic [LOG2N-1:0] r_pb [BFLY_LAT];
  assign w_iss  = r_state == ISSUE;
  // span = N >> (stage+1); the bits of k above span select the group, those below are the index
  assign w_span = HALF >> r_stg;
  assign w_mask = w_span - LOG2N'(1);
  assign w_kx   = LOG2N'(r_k);
  assign w_idx  = w_kx & w_mask;
  assign w_a    = ((w_kx & ~w_mask) << 1) | w_idx;
  assign w_tw   = w_idx << r_stg;
  assign o_wr_en     = r_pv[BFLY_LAT-1];
  assign o_wr_addr_a = r_pa[BFLY_LAT-1];
  assign o_wr_addr_b = r_pb[BFLY_LAT-1];
  // Sequencer state, butterfly index, stage index and drain counter
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= IDLE;
      r_k     <= '0;
      r_stg   <= '0;
      r_d     <= '0;
    end else begin
      r_state <= w_state_nx;
      r_k     <= w_k_nx;
      r_stg   <= w_stg_nx;
      r_d     <= w_d_nx;
    end
  // Next state: abort wins; DRAIN lasts BFLY_LAT cycles so a stage only reads fully written data
  always_comb begin
    w_state_nx = r_state;
    w_k_nx     = r_k;
    w_stg_nx   = r_stg;
    w_d_nx     = r_d;
    if (i_abort) begin
      w_state_nx = IDLE;
      w_k_nx     = '0;
      w_stg_nx   = '0;
      w_d_nx     = '0;
    end else begin
      case (r_state)
        IDLE: if (i_start && !o_done) begin
          w_state_nx = ISSUE;
          w_k_nx     = '0;
          w_stg_nx   = '0;
        end
        ISSUE: begin
          w_k_nx = r_k + KW'(1);
          if (&r_k) begin
            w_state_nx = DRAIN;
            w_d_nx     = '0;
          end
        end
        DRAIN: begin
          w_d_nx = r_d + DW'(1);
          if (r_d == DW'(BFLY_LAT - 1)) begin
            w_d_nx = '0;
            w_k_nx = '0;
            if (r_stg == SW'(LOG2N - 1))
              w_state_nx = DONE;
            else begin
              w_state_nx = ISSUE;
              w_stg_nx   = r_stg + SW'(1);
            end
          end
        end
        DONE: begin
          w_state_nx = IDLE;
          w_stg_nx   = '0;
        end
      endcase
    end
  end
  // Registered issue outputs and the write-back delay line carrying {valid, addr_a, addr_b}
  always_ff @(posedge clk or posedge rst)
    if (rst || i_abort) begin
      o_busy      <= 1'b0;
      o_rd_en     <= 1'b0;
      o_rd_addr_a <= '0;
      o_rd_addr_b <= '0;
      o_tw_addr   <= '0;
      o_stage     <= '0;
      o_done      <= 1'b0;
      for (int i = 0; i < BFLY_LAT; i++) begin
        r_pv[i] <= 1'b0;
        r_pa[i] <= '0;
        r_pb[i] <= '0;
      end
    end else begin
      o_busy      <= w_iss || r_state == DRAIN;
      o_rd_en     <= w_iss;
      o_rd_addr_a <= w_iss ? w_a : '0;
      o_rd_addr_b <= w_iss ? (w_a | w_span) : '0;
      o_tw_addr   <= w_iss ? w_tw[LOG2N-2:0] : '0;
      o_stage     <= w_iss ? r_stg : '0;
      o_done      <= r_state == DONE;
      for (int i = BFLY_LAT - 1; i > 0; i--) begin
        r_pv[i] <= r_pv[i-1];
        r_pa[i] <= r_pa[i-1];
        r_pb[i] <= r_pb[i-1];
      end
      r_pv[0] <= o_rd_en;
      r_pa[0] <= o_rd_addr_a;
      r_pb[0] <= o_rd_addr_b;
    end
endmodule

// File: tb/tb_fft_stage_ctrl.sv
// tb_fft_stage_ctrl: directed table-driven bench for fft_stage_ctrl (BFLY_LAT 4 and 1)
module tb_fft_stage_ctrl;
  typedef struct {
    int         s;
    int         k;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] tw;
  } vec_t;
  logic clk = 1'b0, rst, start, abort, start1, abort1;
  logic busy0, rd0, wr0, done0, busy1, rd1, wr1, done1;
  logic [3:0] ra0, rb0, wa0, wb0, ra1, rb1, wa1, wb1;
  logic [2:0] tw0, tw1;
  logic [1:0] st0, st1;
  logic [24:0] w0, w1;
  int checks = 0, failures = 0;
  vec_t v[32];
  int ta[32] = '{0,1,2,3,4,5,6,7, 0,1,2,3,8,9,10,11, 0,1,4,5,8,9,12,13, 0,2,4,6,8,10,12,14};
  int tb[32] = '{8,9,10,11,12,13,14,15, 4,5,6,7,12,13,14,15, 2,3,6,7,10,11,14,15, 1,3,5,7,9,11,13,15};
  int tt[32] = '{0,1,2,3,4,5,6,7, 0,2,4,6,0,2,4,6, 0,4,0,4,0,4,0,4, 0,0,0,0,0,0,0,0};
  always #5 clk = ~clk;
  fft_stage_ctrl #(.LOG2N(4), .BFLY_LAT(4)) dut (
    .clk(clk), .rst(rst), .i_start(start), .i_abort(abort), .o_busy(busy0), .o_rd_en(rd0),
    .o_rd_addr_a(ra0), .o_rd_addr_b(rb0), .o_tw_addr(tw0), .o_stage(st0), .o_wr_en(wr0),
    .o_wr_addr_a(wa0), .o_wr_addr_b(wb0), .o_done(done0)
  );
  fft_stage_ctrl #(.LOG2N(4), .BFLY_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .i_start(start1), .i_abort(abort1), .o_busy(busy1), .o_rd_en(rd1),
    .o_rd_addr_a(ra1), .o_rd_addr_b(rb1), .o_tw_addr(tw1), .o_stage(st1), .o_wr_en(wr1),
    .o_wr_addr_a(wa1), .o_wr_addr_b(wb1), .o_done(done1)
  );
  assign w0 = {rd0, ra0, rb0, tw0, st0, wr0, wa0, wb0, busy0, done0};
  assign w1 = {rd1, ra1, rb1, tw1, st1, wr1, wa1, wb1, busy1, done1};
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask
  task automatic set_start(input int lat, input logic val);
    if (lat == 4) start = val;
    else start1 = val;
  endtask
  // Expected outputs for cycle T+c of a frame started at edge T, with butterfly latency lat
  task automatic chk_cycle(input string tag, input int c, input int lat, input logic [24:0] act);
    int p, last, s, k, cw, sw, kw;
    logic [24:0] e;
    vec_t vr, vw;
    p = 8 + lat;
    last = 8 + 3 * p + lat;
    e = '0;
    if (c >= 1) begin
      s = (c - 1) / p;
      k = (c - 1) % p;
      if (s < 4 && k < 8) begin
        vr = v[s * 8 + k];
        e[24] = 1'b1;
        e[23:20] = vr.a;
        e[19:16] = vr.b;
        e[15:13] = vr.tw;
        e[12:11] = 2'(vr.s);
      end
    end
    cw = c - lat;
    if (cw >= 1) begin
      sw = (cw - 1) / p;
      kw = (cw - 1) % p;
      if (sw < 4 && kw < 8) begin
        vw = v[sw * 8 + kw];
        e[10] = 1'b1;
        e[9:6] = vw.a;
        e[5:2] = vw.b;
      end
    end
    e[1] = c >= 1 && c <= last;
    e[0] = c == last + 1;
    chk($sformatf("%s T+%0d", tag, c), act, e);
  endtask
  // Full frame; start is also pulsed before edges T+p1 and T+p2 and must be ignored
  task automatic run_frame(input string tag, input int lat, input int p1, input int p2);
    int nrd, nwr, last;
    nrd = 0;
    nwr = 0;
    last = 8 + 3 * (8 + lat) + lat;
    set_start(lat, 1'b1);
    tick;
    set_start(lat, 1'b0);
    chk_cycle(tag, 0, lat, lat == 4 ? w0 : w1);
    for (int c = 1; c <= last + 3; c++) begin
      if (c == p1 || c == p2) set_start(lat, 1'b1);
      tick;
      set_start(lat, 1'b0);
      chk_cycle(tag, c, lat, lat == 4 ? w0 : w1);
      nrd += int'(lat == 4 ? rd0 : rd1);
      nwr += int'(lat == 4 ? wr0 : wr1);
    end
    chk({tag, " rd_en count"}, 64'(nrd), 64'd32);
    chk({tag, " wr_en count"}, 64'(nwr), 64'd32);
  endtask
  initial begin
    int nrd, nwr, nd;
    for (int i = 0; i < 32; i++) v[i] = '{i / 8, i % 8, 4'(ta[i]), 4'(tb[i]), 3'(tt[i])};
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    start1 = 1'b0;
    abort1 = 1'b0;
    repeat (3) tick;
    chk("reset lat4", 64'(w0), 64'd0);
    chk("reset lat1", 64'(w1), 64'd0);
    rst = 1'b0;
    tick;
    chk("idle lat4", 64'(w0), 64'd0);
    run_frame("frame", 4, 0, 0);
    run_frame("ignore", 4, 10, 50);
    run_frame("fresh", 4, 0, 0);
    start = 1'b1;
    abort = 1'b1;
    tick;
    start = 1'b0;
    abort = 1'b0;
    tick;
    chk("abort+start idle", 64'({rd0, busy0, wr0}), 64'd0);
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int c = 1; c <= 19; c++) begin
      tick;
      chk_cycle("pre-abort", c, 4, w0);
    end
    abort = 1'b1;
    tick;
    abort = 1'b0;
    tick;
    chk("abort T+21", 64'({busy0, rd0, wr0, done0}), 64'd0);
    nrd = 0;
    nwr = 0;
    nd = 0;
    for (int c = 22; c <= 60; c++) begin
      tick;
      nrd += int'(rd0);
      nwr += int'(wr0);
      nd += int'(done0) + int'(busy0);
    end
    chk("abort no rd_en", 64'(nrd), 64'd0);
    chk("abort no wr_en", 64'(nwr), 64'd0);
    chk("abort no done/busy", 64'(nd), 64'd0);
    run_frame("post-abort", 4, 0, 0);
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      tick;
      chk_cycle("pre-rst", c, 4, w0);
    end
    #2 rst = 1'b1;
    #1;
    chk("rst async clear", 64'(w0), 64'd0);
    tick;
    #2 rst = 1'b0;
    nrd = 0;
    nwr = 0;
    nd = 0;
    for (int c = 0; c < 30; c++) begin
      tick;
      nrd += int'(rd0);
      nwr += int'(wr0);
      nd += int'(done0) + int'(busy0);
    end
    chk("post-rst no rd_en", 64'(nrd), 64'd0);
    chk("post-rst no wr_en", 64'(nwr), 64'd0);
    chk("post-rst no done/busy", 64'(nd), 64'd0);
    run_frame("post-rst", 4, 0, 0);
    run_frame("lat1", 1, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
